// File: rtl/frame_capture_buffer_pkg.sv
// -----------------------------------------------------------------------------
// frame_capture_buffer_pkg
// Shared constants and state encoding for the frame capture buffer and the VGA
// drawing stage that consumes its flattened frame bus.
//   PIX_W    : width of the signed pixel word on the stream and the frame bus
//   IMG_DIM  : image side in pixels; NPIX is the pixel count of one frame
//   MAX_VAL  : saturation ceiling that matches the 4-bit grey display
//   CNT_W    : width of the published-frame counter
// -----------------------------------------------------------------------------
package frame_capture_buffer_pkg;

    localparam int PIX_W   = 10;
    localparam int IMG_DIM = 14;
    localparam int NPIX    = IMG_DIM * IMG_DIM;
    localparam int MAX_VAL = 15;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = $clog2(NPIX);

    // FILL: the back buffer is accepting pixels.
    // PENDING: a complete frame waits in the back buffer for frame_sync.
    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } fcb_state_t;

endpackage : frame_capture_buffer_pkg

// File: rtl/frame_capture_buffer_saturate.sv
// -----------------------------------------------------------------------------
// pixel_saturate
// Purely combinational clamp of a signed decoder pixel into the display range.
//   pix_in  : signed PIX_W pixel from the decoder
//   pix_out : 0 for negative input, MAX_VAL above the ceiling, else unchanged
// -----------------------------------------------------------------------------
module pixel_saturate
    import frame_capture_buffer_pkg::*;
(
    input  logic signed [PIX_W-1:0] pix_in,
    output logic        [PIX_W-1:0] pix_out
);

    localparam logic [PIX_W-1:0] MAX_PIX = PIX_W'(MAX_VAL);

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pix_out = $unsigned(pix_in);
        if (pix_in[PIX_W-1]) begin
            pix_out = '0;
        end else if ($unsigned(pix_in) > MAX_PIX) begin
            pix_out = MAX_PIX;
        end
    end

endmodule : pixel_saturate

// File: rtl/frame_capture_buffer.sv
// -----------------------------------------------------------------------------
// frame_capture_buffer
// Captures the decoder's 14x14 image from a valid/ready pixel stream into a
// back buffer and publishes it to the VGA drawing stage only on frame_sync,
// so the displayed frame never tears.
//   clk, rst    : system clock, synchronous active-high reset
//   in_valid    : decoder pixel valid
//   in_ready    : buffer accepts a pixel this cycle (registered, FILL only)
//   in_data     : signed decoder pixel, row-major, index 0 = top-left
//   in_last     : marks the final pixel of a frame
//   frame_sync  : one-cycle pulse at the start of vertical blanking
//   out_frame   : displayed frame, pixel i at [i*PIX_W +: PIX_W]
//   frame_count : number of published frames, wraps
//   err_len     : one-cycle pulse after a frame-length error
// -----------------------------------------------------------------------------
module frame_capture_buffer
    import frame_capture_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [PIX_W-1:0] in_data,
    input  logic                    in_last,
    input  logic                    frame_sync,
    output logic [NPIX*PIX_W-1:0]   out_frame,
    output logic [CNT_W-1:0]        frame_count,
    output logic                    err_len
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    fcb_state_t       state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             front_sel_q;
    logic             ready_q;
    logic             accept;
    logic             swap;
    logic             err_d;
    logic [PIX_W-1:0] sat_pix;

    // Two frame stores; front_sel_q picks the one shown, the other is written.
    logic [PIX_W-1:0] frame_mem [2][NPIX];

    pixel_saturate u_saturate (
        .pix_in  (in_data),
        .pix_out (sat_pix)
    );

    // ready_q mirrors (state == FILL) but is held low through reset, so the
    // handshake never depends on in_valid or on the raw reset input.
    assign in_ready = ready_q;
    assign accept   = in_valid && ready_q;

    // Next-state logic. A frame is complete when the pixel at the last index
    // is taken, whether or not in_last came with it; an in_last seen earlier
    // throws the partial frame away.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        err_d    = 1'b0;
        swap     = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = PENDING;
                        err_d    = !in_last;
                    end else if (in_last) begin
                        wr_idx_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            PENDING: begin
                if (frame_sync) begin
                    swap    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_idx_q    <= '0;
            front_sel_q <= 1'b0;
            ready_q     <= 1'b0;
            frame_count <= '0;
            err_len     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            ready_q  <= (state_d == FILL);
            err_len  <= err_d;
            if (swap) begin
                front_sel_q <= ~front_sel_q;
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

    // NOTE: the frame stores are reset deliberately: a reset must blank the
    // display, so both buffers are cleared rather than left undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NPIX; i++) begin
                    frame_mem[b][i] <= '0;
                end
            end
        end else if (accept && (state_q == FILL)) begin
            frame_mem[~front_sel_q][wr_idx_q] <= sat_pix;
        end
    end

    // Front buffer is never written, so this bus only changes on a swap.
    always_comb begin
        out_frame = '0;
        for (int i = 0; i < NPIX; i++) begin
            out_frame[i*PIX_W +: PIX_W] = frame_mem[front_sel_q][i];
        end
    end

endmodule : frame_capture_buffer

// File: tb/tb_frame_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_frame_capture_buffer
// Self-checking bench for frame_capture_buffer. Expected frames are queued as
// they are streamed in and compared against out_frame when published.
// -----------------------------------------------------------------------------
module tb_frame_capture_buffer;
    import frame_capture_buffer_pkg::*;

    typedef logic [NPIX*PIX_W-1:0] frame_vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [PIX_W-1:0] in_data;
    logic                    in_last;
    logic                    frame_sync;
    frame_vec_t              out_frame;
    logic [CNT_W-1:0]        frame_count;
    logic                    err_len;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         err_seen = 0;
    int         err_exp  = 0;
    int         cnt_exp  = 0;
    frame_vec_t exp_q[$];
    frame_vec_t disp;
    int         pix[NPIX];

    always #5 clk = ~clk;

    frame_capture_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .frame_sync  (frame_sync),
        .out_frame   (out_frame),
        .frame_count (frame_count),
        .err_len     (err_len)
    );

    // Count every cycle err_len is high; a stuck pulse shows up as extras.
    always @(negedge clk) begin
        if (err_len === 1'b1) err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > MAX_VAL) return MAX_VAL;
        return v;
    endfunction

    function automatic frame_vec_t build_vec();
        frame_vec_t v = '0;
        for (int k = 0; k < NPIX; k++) v[k*PIX_W +: PIX_W] = PIX_W'(sat(pix[k]));
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input frame_vec_t exp);
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("%s px%0d", tag, i),
                  32'(out_frame[i*PIX_W +: PIX_W]), 32'(exp[i*PIX_W +: PIX_W]));
        end
    endtask

    task automatic send_pixel(input int v, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = PIX_W'(v);
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        if (n >= 50) check("ready_timeout", n, 0);
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stream_frame(input int n, input int last_at, input bit push);
        for (int k = 0; k < n; k++) send_pixel(pix[k], k == last_at);
        if (push) exp_q.push_back(build_vec());
    endtask

    task automatic publish(input string tag);
        frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        cnt_exp = (cnt_exp + 1) % (1 << CNT_W);
        check({tag, " queued"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) disp = exp_q.pop_front();
        check_frame(tag, disp);
        check({tag, " count"}, frame_count, cnt_exp);
        check({tag, " ready"}, in_ready, 1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        frame_sync = 1'b0;
        disp       = '0;

        // 1. reset
        repeat (3) begin
            cycle();
            check("rst ready", in_ready, 0);
        end
        check_frame("rst frame", '0);
        check("rst count", frame_count, 0);
        check("rst err", err_len, 0);
        rst = 1'b0;
        cycle();
        check("post-rst ready", in_ready, 1);

        // 2. full frame, sync 10 cycles later
        for (int k = 0; k < NPIX; k++) pix[k] = k % 16;
        stream_frame(NPIX, NPIX - 1, 1'b1);
        repeat (10) begin
            check("pending ready", in_ready, 0);
            cycle();
        end
        check_frame("pre-sync frame", disp);
        publish("full");

        // 3. saturation
        for (int k = 0; k < NPIX; k++) pix[k] = 3;
        pix[0] = -5; pix[1] = 16; pix[2] = 511; pix[3] = -512; pix[4] = 7;
        stream_frame(NPIX, NPIX - 1, 1'b1);
        publish("sat");
        check("sat p0", 32'(out_frame[0*PIX_W +: PIX_W]), 0);
        check("sat p1", 32'(out_frame[1*PIX_W +: PIX_W]), 15);
        check("sat p2", 32'(out_frame[2*PIX_W +: PIX_W]), 15);
        check("sat p3", 32'(out_frame[3*PIX_W +: PIX_W]), 0);
        check("sat p4", 32'(out_frame[4*PIX_W +: PIX_W]), 7);

        // 4. early last on pixel 100
        for (int k = 0; k < NPIX; k++) pix[k] = 5;
        stream_frame(101, 100, 1'b0);
        err_exp++;
        check("early err pulse", err_len, 1);
        check("early ready", in_ready, 1);
        cycle();
        check("early err clear", err_len, 0);
        check_frame("early frame", disp);
        for (int k = 0; k < NPIX; k++) pix[k] = (k * 7) % 16;
        pix[0] = 12;
        stream_frame(NPIX, NPIX - 1, 1'b1);
        publish("after-early");
        check("early err count", err_seen, err_exp);

        // 5. frame_sync collides with last pixel; valid held during PENDING
        for (int k = 0; k < NPIX; k++) pix[k] = 15 - (k % 16);
        stream_frame(NPIX - 1, -1, 1'b0);
        in_valid   = 1'b1;
        in_data    = PIX_W'(pix[NPIX-1]);
        in_last    = 1'b1;
        frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        in_last    = 1'b0;
        in_data    = PIX_W'(9);
        exp_q.push_back(build_vec());
        check("collide count", frame_count, cnt_exp);
        check_frame("collide frame", disp);
        check("collide ready", in_ready, 0);
        repeat (5) begin
            cycle();
            check("pending valid ready", in_ready, 0);
        end
        publish("collide");
        for (int k = 0; k < NPIX; k++) pix[k] = k % 3;
        pix[0] = 9;
        stream_frame(NPIX, NPIX - 1, 1'b1);
        publish("held-pixel");

        // 6a. missing last
        for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom_range(0, 110)) - 50;
        stream_frame(NPIX, -1, 1'b1);
        err_exp++;
        check("nolast err pulse", err_len, 1);
        publish("nolast");
        check("nolast err count", err_seen, err_exp);

        // 6b. reset mid-frame
        for (int k = 0; k < NPIX; k++) pix[k] = 8;
        stream_frame(50, -1, 1'b0);
        rst = 1'b1;
        cycle();
        cycle();
        check_frame("midrst frame", '0);
        check("midrst count", frame_count, 0);
        check("midrst ready", in_ready, 0);
        rst = 1'b0;
        cycle();
        disp    = '0;
        cnt_exp = 0;
        for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom_range(0, 30)) - 7;
        stream_frame(NPIX, NPIX - 1, 1'b1);
        publish("post-rst");
        check("final err count", err_seen, err_exp);
        check("queue drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_frame_capture_buffer
